serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start_i  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a_i  input  WIDTH  minuend, unsigned; captured on the accepting edge.
REQ-006 SHALL have port: b_i  input  WIDTH  subtrahend, unsigned; captured on the accepting edge.
REQ-007 SHALL have port: busy_o  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port: done_o  output  1  single-cycle completion pulse.
REQ-009 SHALL have port: diff_o  output  WIDTH  registered result (a - b) mod 2^WIDTH.
REQ-010 SHALL have port: borrow_o  output  1  registered final borrow; 1 iff a < b.
REQ-011 SHALL have port: zero_o  output  1  registered flag; 1 iff the diff_o result is 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start_i=1 at an edge (accept edge E0), load a_i and b_i into internal shift registers, clear borrow flop and bit counter, and enter RUN.
REQ-014 SHALL remain in IDLE while start_i=0; outputs hold.
REQ-015 SHALL, in RUN, process one bit per edge, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 SHALL shift both operand registers right one bit per RUN edge and shift d into the MSB of an internal difference register.
REQ-017 SHALL use a counter of ceil(log2(WIDTH)) bits; on the RUN edge with count = WIDTH-1 (edge E_WIDTH), enter DONE.
REQ-018 SHALL, on edge E_WIDTH, load diff_o with the completed difference, borrow_o with br_next, and zero_o with (difference == 0).
REQ-019 SHALL hold diff_o/borrow_o/zero_o stable at all other times, including throughout RUN.
REQ-020 SHALL drive done_o=1 only while in DONE (exactly one cycle, starting WIDTH edges after E0); DONE always returns to IDLE on the next edge.
REQ-021 SHALL ignore start_i in RUN and DONE; no queuing. Minimum accept-to-accept spacing is WIDTH+2 edges.
REQ-022 SHALL ignore a_i/b_i changes after E0 until the next accept.
REQ-023 SHALL produce a correct result for all operand pairs, including a = b, a = 0, b = 0, and full-length borrow chains.

Reset
REQ-024 SHALL, while rst_i=1, immediately (without a clock edge) force state IDLE, busy_o=0, done_o=0, diff_o=0, borrow_o=0, zero_o=0, counter=0, and clear all internal shift registers and the borrow flop.
REQ-025 SHALL, when rst_i is asserted mid-RUN or in DONE, abort the operation with no done_o pulse and no result update.
REQ-026 SHALL accept a start on the first rising edge after rst_i deasserts if start_i=1.

Verification (WIDTH=8)
REQ-027 SHALL pass: a=0x5A, b=0x23, start pulse -> busy_o high from E0; done_o one cycle after E8; diff_o=0x37, borrow_o=0, zero_o=0.
REQ-028 SHALL pass: a=0x10, b=0x20 -> diff_o=0xF0, borrow_o=1, zero_o=0.
REQ-029 SHALL pass: a=0x7F, b=0x7F -> diff_o=0x00, borrow_o=0, zero_o=1; a=0x00, b=0xFF -> diff_o=0x01, borrow_o=1.
REQ-030 SHALL pass: start_i held high continuously with a_i/b_i changed every cycle -> results match operands sampled at each accept edge; accepts exactly 10 edges apart; one done_o per operation.
REQ-031 SHALL pass: rst_i pulsed asynchronously between edges during RUN (after E3) -> busy_o and all outputs 0 immediately, no done_o; next operation 0x05-0x03 -> diff_o=0x02.
REQ-032 SHALL pass: during RUN, diff_o/borrow_o/zero_o keep the previous operation's values until E8.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// with a registered result, final borrow and zero flag published on the last RUN edge.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zero_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               zero_q, zero_d;

    // One full-subtractor cell, fed from the LSBs of the operand shift registers.
    logic             a0, b0, d_bit, br_next;
    logic [WIDTH-1:0] diff_next;

    assign a0        = a_sr_q[0];
    assign b0        = b_sr_q[0];
    assign d_bit     = a0 ^ b0 ^ br_q;
    assign br_next   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    assign diff_next = {d_bit, diff_sr_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        zero_d    = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sr_d    = a_i;
                    b_sr_d    = b_i;
                    diff_sr_d = '0;
                    br_d      = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                diff_sr_d = diff_next;
                br_d      = br_next;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Result registers only move here, so they hold through RUN.
                    cnt_d    = '0;
                    diff_d   = diff_next;
                    borrow_d = br_next;
                    zero_d   = (diff_next == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            br_q      <= br_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            zero_q    <= zero_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed vectors, hold/timing,
// continuous-start spacing and asynchronous abort.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             zero_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] prev_diff;
    logic             prev_borrow;
    logic             prev_zero;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full operation from IDLE; operands are scrambled after E0 to show they are not re-sampled.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_br, input logic exp_z);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        tick();                                   // E0
        start_i = 1'b0;
        a_i     = ~a;
        b_i     = a ^ 8'h3C;
        check({tag, " busy@E0"}, busy_o, 1);
        for (int k = 1; k < 8; k++) begin
            tick();                               // E1..E7
            check({tag, " no_done_run"}, done_o, 0);
            check({tag, " diff_hold_run"}, {diff_o, borrow_o, zero_o}, {prev_diff, prev_borrow, prev_zero});
        end
        tick();                                   // E8
        check({tag, " done"}, done_o, 1);
        check({tag, " busy_in_done"}, busy_o, 1);
        check({tag, " diff"}, diff_o, exp_d);
        check({tag, " borrow"}, borrow_o, exp_br);
        check({tag, " zero"}, zero_o, exp_z);
        tick();                                   // E9
        check({tag, " done_single"}, done_o, 0);
        check({tag, " idle"}, busy_o, 0);
        check({tag, " diff_hold_idle"}, {diff_o, borrow_o, zero_o}, {exp_d, exp_br, exp_z});
        prev_diff   = exp_d;
        prev_borrow = exp_br;
        prev_zero   = exp_z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] acc_a, acc_b, fa, fb;
        int         dones;

        rst_i   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_zero   = 1'b0;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst_i = 1'b1;
        #2;
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset outs", {diff_o, borrow_o, zero_o}, 0);
        tick();
        tick();
        rst_i = 1'b0;

        // First rising edge after reset release accepts.
        do_op("sub_5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        tick();
        tick();
        check("idle_hold busy", busy_o, 0);
        check("idle_hold outs", {diff_o, borrow_o, zero_o}, {8'h37, 1'b0, 1'b0});

        do_op("sub_10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        do_op("sub_7f_7f", 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1);
        do_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        do_op("sub_a5_00", 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);
        do_op("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        do_op("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        do_op("sub_80_7f", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

        // start_i held high with operands changing every cycle: accepts at edges 0, 10, 20.
        start_i = 1'b1;
        dones   = 0;
        acc_a   = '0;
        acc_b   = '0;
        for (int e = 0; e < 30; e++) begin
            fa  = 8'(e * 17 + 3);
            fb  = 8'(e * 29 + 100);
            a_i = fa;
            b_i = fb;
            tick();
            if (e % 10 == 0) begin
                acc_a = fa;
                acc_b = fb;
            end
            if (done_o === 1'b1) dones++;
            check("cont busy", busy_o, (e % 10 != 9) ? 1 : 0);
            check("cont done", done_o, (e % 10 == 8) ? 1 : 0);
            if (e % 10 == 8) begin
                check("cont diff", diff_o, 8'(acc_a - acc_b));
                check("cont borrow", borrow_o, (acc_a < acc_b) ? 1 : 0);
                check("cont zero", zero_o, (acc_a == acc_b) ? 1 : 0);
            end
        end
        start_i = 1'b0;
        check("cont done_count", dones, 3);
        prev_diff   = diff_o === 8'(8'd173 - 8'd168) ? 8'd5 : 8'(8'd173 - 8'd168);
        prev_borrow = 1'b0;
        prev_zero   = 1'b0;
        tick();

        // Abort mid-RUN: reset between edges after E3 clears everything at once.
        a_i     = 8'hFF;
        b_i     = 8'h01;
        start_i = 1'b1;
        tick();                                   // E0
        start_i = 1'b0;
        tick();
        tick();
        tick();                                   // E3
        #2 rst_i = 1'b1;
        #1;
        check("abort busy", busy_o, 0);
        check("abort done", done_o, 0);
        check("abort outs", {diff_o, borrow_o, zero_o}, 0);
        #1 rst_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
        end
        check("abort no_done", dones, 0);
        prev_diff   = '0;
        prev_borrow = 1'b0;
        prev_zero   = 1'b0;
        do_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
